// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC,
// canonical NOP and AXI read response codes.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_HOLD
  } ifu_state_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding AXI-style read, result held for decode.
// Optional response checking is enabled by defining IFU_RESP_CHK_EN.
module ifu
  import ifu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        inst_r_ready,
  output logic        inst_r_valid,
  input  logic        redirect,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        if_id_valid,
  input  logic        id_ready,
  output logic        if_id_handshake,
  output logic        fetch_err
);

  ifu_state_e state, state_next;
  logic       discard;
  logic       fetch_err_q;
  logic       resp_err;
  logic       start;
  logic       drop;

`ifdef IFU_RESP_CHK_EN
  assign resp_err = (axi_resp_e'(rresp) != RESP_OKAY);
`else
  logic unused_rresp;
  assign unused_rresp = ^rresp;
  assign resp_err     = 1'b0;
`endif

  assign start           = inst_r_ready && !redirect;
  // A response is dropped if a redirect arrived earlier in flight or with it.
  assign drop            = discard || redirect;
  assign rready          = (state == S_R);
  assign inst_r_valid    = rready && rvalid;
  assign if_id_handshake = if_id_valid && id_ready;
  assign fetch_err       = fetch_err_q && if_id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_AR;
      S_AR:   if (arready) state_next = S_R;
      S_R:    if (rvalid) state_next = drop ? S_IDLE : S_HOLD;
      S_HOLD: if (redirect || id_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr      <= RESET_PC;
      arvalid     <= 1'b0;
      discard     <= 1'b0;
      if_id_valid <= 1'b0;
      fetch_err_q <= 1'b0;
      inst        <= NOP_INST;
      inst_pc     <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: begin
          discard <= 1'b0;
          if (start) begin
            araddr  <= pc;
            arvalid <= 1'b1;
          end
        end
        S_AR: begin
          if (redirect) discard <= 1'b1;
          if (arready)  arvalid <= 1'b0;
        end
        S_R: begin
          if (rvalid) begin
            discard <= 1'b0;
            if (!drop) begin
              inst        <= resp_err ? NOP_INST : rdata;
              inst_pc     <= araddr;
              fetch_err_q <= resp_err;
              if_id_valid <= 1'b1;
            end
          end else if (redirect) begin
            discard <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect || id_ready) if_id_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
